// File: rtl/ct_f_spsram_param_pkg.sv
// Shared definitions for ct_f_spsram_param: controller state encoding and the
// slice-divisibility check used at elaboration.
`ifndef CT_F_SPSRAM_PARAM_PKG_SV
`define CT_F_SPSRAM_PARAM_PKG_SV

`define CT_F_SPSRAM_DIV_CHECK(DW, WN) (((DW) % (WN)) == 0)

package ct_f_spsram_param_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } spsram_state_t;

endpackage

`endif

// File: rtl/fpga_ram.sv
// Generic FPGA block RAM slice: one port, synchronous write-first read with
// a registered read output.
module fpga_ram #(
   parameter int WIDTH      = 42,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      din,
   input  logic                  we,
   output logic [WIDTH-1:0]      dout
);

   logic [WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];
   logic [WIDTH-1:0] dout_r;

   // Write-first port: a write returns the data being written.
   always_ff @(posedge CLK) begin
      if (we) begin
         mem_r[addr] <= din;
         dout_r      <= din;
      end else begin
         dout_r      <= mem_r[addr];
      end
   end

   assign dout = dout_r;

endmodule

// File: rtl/ct_f_spsram_param.sv
// Parametrised single-port SRAM wrapper with post-reset zero-fill engine and
// deselect read hold. Optional output register: define CT_F_SPSRAM_OREG_EN.
module ct_f_spsram_param
   import ct_f_spsram_param_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 84,
   parameter int WRAP_NUM   = 2
) (
   input  logic                  CLK,
   input  logic                  cpurst_b,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic                  CEN,
   input  logic                  GWEN,
   input  logic [DATA_WIDTH-1:0] WEN,
   input  logic [DATA_WIDTH-1:0] D,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  INIT_DONE
);

   localparam int DEPTH     = 2**ADDR_WIDTH;
   localparam int WRAP_SIZE = DATA_WIDTH / WRAP_NUM;

   if (!(`CT_F_SPSRAM_DIV_CHECK(DATA_WIDTH, WRAP_NUM))) begin : g_div_err
      $error("ct_f_spsram_param: DATA_WIDTH must be divisible by WRAP_NUM");
   end

   spsram_state_t           state_r;
   spsram_state_t           state_nxt_s;
   logic [ADDR_WIDTH-1:0]   init_cnt_r;
   logic [ADDR_WIDTH-1:0]   addr_holding_r;
   logic                    init_last_s;
   logic [ADDR_WIDTH-1:0]   ram_addr_s;
   logic [WRAP_NUM-1:0]     ram_we_s;
   logic [DATA_WIDTH-1:0]   ram_din_s;
   logic [DATA_WIDTH-1:0]   ram_q_s;
   logic [DATA_WIDTH-1:0]   q_mux_s;
   logic                    wen_unused_s;

   // Only the top bit of each slice's WEN field is meaningful.
   assign wen_unused_s = ^WEN;

   assign init_last_s = (init_cnt_r == ADDR_WIDTH'(DEPTH - 1));

   // Next-state: INIT sweeps every address once, then READY until reset.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_INIT: begin
            if (init_last_s) begin
               state_nxt_s = ST_READY;
            end else begin
               state_nxt_s = ST_INIT;
            end
         end
         ST_READY: state_nxt_s = ST_READY;
         default:  state_nxt_s = ST_INIT;
      endcase
   end

   // State, clear counter and held address.
   always_ff @(posedge CLK) begin
      if (!cpurst_b) begin
         state_r        <= ST_INIT;
         init_cnt_r     <= {ADDR_WIDTH{1'b0}};
         addr_holding_r <= {ADDR_WIDTH{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         if (state_r == ST_INIT) begin
            init_cnt_r <= init_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
         end
         if ((state_r == ST_READY) && !CEN) begin
            addr_holding_r <= A;
         end
      end
   end

   // RAM port steering: zero-fill during INIT, user access (or held re-read) in READY.
   always_comb begin
      ram_addr_s = {ADDR_WIDTH{1'b0}};
      ram_we_s   = {WRAP_NUM{1'b0}};
      ram_din_s  = {DATA_WIDTH{1'b0}};
      if (state_r == ST_INIT) begin
         ram_addr_s = init_cnt_r;
         ram_we_s   = {WRAP_NUM{1'b1}};
         ram_din_s  = {DATA_WIDTH{1'b0}};
      end else begin
         ram_addr_s = CEN ? addr_holding_r : A;
         ram_din_s  = D;
         for (int k = 0; k < WRAP_NUM; k++) begin
            ram_we_s[k] = ~CEN & ~GWEN & ~WEN[(k+1)*WRAP_SIZE-1];
         end
      end
   end

   for (genvar k = 0; k < WRAP_NUM; k++) begin : g_slice
      fpga_ram #(
         .WIDTH      (WRAP_SIZE),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_ram (
         .CLK  (CLK),
         .addr (ram_addr_s),
         .din  (ram_din_s[k*WRAP_SIZE +: WRAP_SIZE]),
         .we   (ram_we_s[k]),
         .dout (ram_q_s[k*WRAP_SIZE +: WRAP_SIZE])
      );
   end

   assign q_mux_s = (state_r == ST_READY) ? ram_q_s : {DATA_WIDTH{1'b0}};

`ifdef CT_F_SPSRAM_OREG_EN
   logic [DATA_WIDTH-1:0] q_oreg_r;
   logic                  init_done_d_r;

   // Extra output stage; INIT_DONE trails by one so the first READY Q is valid.
   always_ff @(posedge CLK) begin
      if (!cpurst_b) begin
         q_oreg_r      <= {DATA_WIDTH{1'b0}};
         init_done_d_r <= 1'b0;
      end else begin
         q_oreg_r      <= q_mux_s;
         init_done_d_r <= (state_r == ST_READY);
      end
   end

   assign Q         = q_oreg_r;
   assign INIT_DONE = init_done_d_r;
`else
   assign Q         = q_mux_s;
   assign INIT_DONE = (state_r == ST_READY);
`endif

endmodule

// File: doc/ct_f_spsram_param.md
Name: ct_f_spsram_param

Overview:
- Parametrised FPGA single-port SRAM wrapper. Generalises the fixed 256x84 two-slice wrapper to any depth, width and slice count.
- Adds a post-reset zero-initialisation engine with a ready flag, and a read-data hold while the RAM is deselected.
- Sits under the cache/BHT/TLB array wrappers in the FPGA build. It replaces per-size wrappers.
- Storage is WRAP_NUM instances of fpga_ram sharing one address.

Parameters:
- ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 84, total data width.
- WRAP_NUM, 2, number of fpga_ram slices. DATA_WIDTH must be divisible by WRAP_NUM; otherwise it is an elaboration error. WRAP_SIZE = DATA_WIDTH/WRAP_NUM.

Ports:
- CLK  input  1  array clock; the only clock.
- cpurst_b  input  1  reset, synchronous, active-low.
- A  input  ADDR_WIDTH  address.
- CEN  input  1  chip enable, active-low.
- GWEN  input  1  global write enable, active-low.
- WEN  input  DATA_WIDTH  per-bit write enable, active-low. Only bit (k+1)*WRAP_SIZE-1 is sampled for slice k.
- D  input  DATA_WIDTH  write data; slice k is D[(k+1)*WRAP_SIZE-1 : k*WRAP_SIZE].
- Q  output  DATA_WIDTH  read data.
- INIT_DONE  output  1  high once the array has been cleared after reset.

Behaviour:
- Reset and clocking are as fixed above: one clock CLK; cpurst_b is synchronous and active-low.
- State machine: INIT and READY. While cpurst_b=0, the block is held in INIT with init_cnt=0, addr_holding=0 and INIT_DONE=0.
- INIT:
  - Every cycle, write zero into all slices at address init_cnt, then increment init_cnt.
  - When init_cnt=DEPTH-1 is written, go to READY on the next edge. INIT therefore lasts exactly DEPTH cycles after reset release.
  - External CEN/GWEN/WEN/D/A are ignored. Q=0.
- READY (INIT_DONE=1):
  - Slice write enable k = !CEN && !GWEN && !WEN[(k+1)*WRAP_SIZE-1].
  - Effective address = CEN ? addr_holding : A. addr_holding <= A on every edge with CEN=0.
  - Read latency is 1 cycle: Q is valid on the cycle after a CEN=0 access.
  - While CEN stays 1, Q keeps showing the last accessed entry, because the held address is re-read.
  - Read during write, same cycle: written slices return the new D; unwritten slices return the old contents.
- Reset mid-INIT: init_cnt restarts at 0 and the full DEPTH-cycle clear is repeated.
- Reset in READY: returns to INIT. Array contents are cleared again.
- init_cnt is ADDR_WIDTH bits wide. It wraps to 0 at exit; this is harmless because the state is READY.
- Q while INIT_DONE=0 is forced to 0 by an output mux, not taken from the RAM.

Optional Feature:
- Macro: CT_F_SPSRAM_OREG_EN.
- Defined:
  - Q is registered once more: read latency is 2 cycles.
  - The register updates every cycle and resets to 0.
  - INIT_DONE is delayed by one cycle so that the first READY Q is valid.
- Undefined: latency 1, no extra register, timing as in Behaviour.

Decomposition:
- Shared header: state encoding (INIT=1'b0, READY=1'b1) and the divisibility check macro.
- Sub-module: the existing fpga_ram, used unchanged, instantiated WRAP_NUM times in a generate loop.
- No new sub-module; the init engine and address hold stay in ct_f_spsram_param.

Test Plan:
- Default parameters; release reset; count cycles -> INIT_DONE rises exactly 256 cycles later (257 with OREG). Reads of addresses 0x00, 0x7F and 0xFF then return 0.
- Write A=0x12, D=84'hABC..., GWEN=0, WEN=0, then read 0x12 -> Q equals the written D one cycle later.
- Partial write A=0x12, WEN[41]=1, WEN[83]=0, D=all-ones -> Q[83:42]=all-ones and Q[41:0] unchanged.
- Read 0x12, then hold CEN=1 for 5 cycles with A toggling randomly -> Q stays at the 0x12 data; GWEN=0 with CEN=1 writes nothing.
- Assert cpurst_b=0 at init cycle 100, release -> INIT_DONE after a full 256 cycles. Writes attempted during INIT are dropped; the array reads all zeros.
- ADDR_WIDTH=4, DATA_WIDTH=96, WRAP_NUM=4; write distinct slice patterns to address 0xF -> each slice reads back independently; INIT lasts 16 cycles.
